// File: rtl/l1_cache_pair_complex.sv
// l1_cache_pair_complex
//   Two private direct-mapped write-back L1 data caches (port a = cache 0,
//   port b = cache 1) kept coherent with MSI by a shared snooper, which also
//   owns the single line-wide downstream port to L2.
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   addr_in_x, data_in_x        CPU byte address / write data (x = a, b)
//   rden_x, wren_x              one-cycle request strobes (wren wins)
//   interface_ready_x           port accepts a request this cycle
//   data_out_x, _valid_x        read data, one-cycle valid pulse
//   mem_addr_StoD ...           downstream command (enable is a 1-cycle pulse)
//   cacheline_DtoS, valid_DtoS  downstream response, client_id_DtoS echoes id
//   pause_processors            snooper is outside IDLE
module l1_cache_pair_complex #(
   parameter int NUM_LINES = 16,
   parameter int LINE_BITS = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          addr_in_a,
   input  logic [31:0]          data_in_a,
   input  logic                 rden_a,
   input  logic                 wren_a,
   output logic                 interface_ready_a,
   output logic [31:0]          data_out_a,
   output logic                 data_out_valid_a,
   input  logic [31:0]          addr_in_b,
   input  logic [31:0]          data_in_b,
   input  logic                 rden_b,
   input  logic                 wren_b,
   output logic                 interface_ready_b,
   output logic [31:0]          data_out_b,
   output logic                 data_out_valid_b,
   output logic [31:0]          mem_addr_StoD,
   output logic [LINE_BITS-1:0] cacheline_StoD,
   output logic                 wren_StoD,
   output logic                 rden_StoD,
   output logic                 downstream_enable,
   output logic                 client_id_StoD,
   input  logic [LINE_BITS-1:0] cacheline_DtoS,
   input  logic                 valid_DtoS,
   input  logic                 client_id_DtoS,
   output logic                 pause_processors
);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = 28 - IW;
   localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;
   localparam logic [2:0] IDLE = 3'd0, SNOOP = 3'd1, WB_OTHER = 3'd2,
                          WB_VICTIM = 3'd3, FETCH = 3'd4, FILL = 3'd5;

   logic [1:0][NUM_LINES-1:0][1:0]           st_q, st_d;
   logic [1:0][NUM_LINES-1:0][TW-1:0]        tag_q, tag_d;
   logic [1:0][NUM_LINES-1:0][LINE_BITS-1:0] dat_q, dat_d;
   logic [1:0]        ready_q, ready_d, pend_q, pend_d, pwr_q, pwr_d, vld_q, vld_d;
   logic [1:0][31:0]  paddr_q, paddr_d, pdat_q, pdat_d, dout_q, dout_d;
   logic [2:0]        fsm_q, fsm_d;
   logic              cur_q, cur_d, iss_q, iss_d, rr_q, rr_d;
   logic [LINE_BITS-1:0] fill_q, fill_d, ds_line_q, ds_line_d;
   logic [31:0]       ds_addr_q, ds_addr_d;
   logic              ds_en_q, ds_en_d, ds_wr_q, ds_wr_d, ds_rd_q, ds_rd_d, ds_id_q, ds_id_d;

   // CPU ports as arrays so both caches share one code path
   logic [1:0]       rden, wren;
   logic [1:0][31:0] addr, wdata;
   assign rden  = {rden_b, rden_a};
   assign wren  = {wren_b, wren_a};
   assign addr  = {addr_in_b, addr_in_a};
   assign wdata = {data_in_b, data_in_a};

   // Request currently owned by the snooper: c = requester, o = other cache
   logic          c, o, pw, own_hit, oth_has, resp;
   logic [IW-1:0] pidx;
   logic [TW-1:0] ptag;
   logic [1:0]    pws;
   assign c       = cur_q;
   assign o       = ~cur_q;
   assign pidx    = paddr_q[c][IW+3:4];
   assign ptag    = paddr_q[c][31:IW+4];
   assign pws     = paddr_q[c][3:2];
   assign pw      = pwr_q[c];
   assign own_hit = (st_q[c][pidx] != ST_I) && (tag_q[c][pidx] == ptag);
   assign oth_has = (st_q[o][pidx] != ST_I) && (tag_q[o][pidx] == ptag);
   assign resp    = valid_DtoS && (client_id_DtoS == c);

   logic unused;
   assign unused = ^{paddr_q[0][1:0], paddr_q[1][1:0]};

   always_comb begin
      logic [IW-1:0]        idx;
      logic [TW-1:0]        tg;
      logic [1:0]           ws;
      logic                 hit, clash;
      logic [LINE_BITS-1:0] merged;
      idx = '0; tg = '0; ws = '0; hit = 1'b0; clash = 1'b0; merged = fill_q;
      st_d = st_q; tag_d = tag_q; dat_d = dat_q;
      ready_d = ready_q; pend_d = pend_q; pwr_d = pwr_q; paddr_d = paddr_q;
      pdat_d = pdat_q; dout_d = dout_q; vld_d = '0;
      fsm_d = fsm_q; cur_d = cur_q; iss_d = iss_q; rr_d = rr_q; fill_d = fill_q;
      ds_en_d = 1'b0; ds_wr_d = 1'b0; ds_rd_d = 1'b0;
      ds_addr_d = ds_addr_q; ds_line_d = ds_line_q; ds_id_d = ds_id_q;

      // Local hit path. Anything needing coherence work, or touching the
      // index the snooper is working on, is parked for the snooper.
      for (int x = 0; x < 2; x++) begin
         idx   = addr[x][IW+3:4];
         tg    = addr[x][31:IW+4];
         ws    = addr[x][3:2];
         hit   = (st_q[x][idx] != ST_I) && (tag_q[x][idx] == tg);
         clash = (fsm_q != IDLE) && (idx == pidx);
         if (ready_q[x] && (rden[x] || wren[x])) begin
            if (hit && !clash && !(wren[x] && st_q[x][idx] == ST_S)) begin
               if (wren[x]) dat_d[x][idx][{ws, 5'd0} +: 32] = wdata[x];
               else begin
                  dout_d[x] = dat_q[x][idx][{ws, 5'd0} +: 32];
                  vld_d[x]  = 1'b1;
               end
            end else begin
               pend_d[x]  = 1'b1;
               ready_d[x] = 1'b0;
               pwr_d[x]   = wren[x];
               paddr_d[x] = addr[x];
               pdat_d[x]  = wdata[x];
            end
         end
      end

      case (fsm_q)
         IDLE: begin
            // Priority flips only on a real collision, so the loser goes first next time
            if (pend_q[0] && pend_q[1]) begin
               cur_d = rr_q;
               rr_d  = ~rr_q;
               fsm_d = SNOOP;
            end else if (pend_q != 2'b00) begin
               cur_d = pend_q[1];
               fsm_d = SNOOP;
            end
         end
         SNOOP: begin
            // Request is re-evaluated here: it may have become a hit meanwhile
            if (own_hit) begin
               if (!pw) begin
                  dout_d[c] = dat_q[c][pidx][{pws, 5'd0} +: 32];
                  vld_d[c]  = 1'b1;
               end else begin
                  dat_d[c][pidx][{pws, 5'd0} +: 32] = pdat_q[c];
                  st_d[c][pidx] = ST_M;
                  if (oth_has) st_d[o][pidx] = ST_I;
               end
               pend_d[c] = 1'b0; ready_d[c] = 1'b1; fsm_d = IDLE;
            end else if (oth_has && st_q[o][pidx] == ST_M) begin
               fsm_d = WB_OTHER;
            end else begin
               if (pw && oth_has) st_d[o][pidx] = ST_I;
               fsm_d = WB_VICTIM;
            end
         end
         WB_OTHER: begin
            if (!iss_q) begin
               ds_en_d = 1'b1; ds_wr_d = 1'b1; ds_id_d = c; iss_d = 1'b1;
               ds_addr_d = {ptag, pidx, 4'b0};
               ds_line_d = dat_q[o][pidx];
            end else if (resp) begin
               iss_d = 1'b0;
               st_d[o][pidx] = pw ? ST_I : ST_S;
               fsm_d = WB_VICTIM;
            end
         end
         WB_VICTIM: begin
            if (st_q[c][pidx] != ST_M) fsm_d = FETCH;
            else if (!iss_q) begin
               ds_en_d = 1'b1; ds_wr_d = 1'b1; ds_id_d = c; iss_d = 1'b1;
               ds_addr_d = {tag_q[c][pidx], pidx, 4'b0};
               ds_line_d = dat_q[c][pidx];
            end else if (resp) begin
               // Drop the victim so this state does not write it back again
               iss_d = 1'b0;
               st_d[c][pidx] = ST_I;
               fsm_d = FETCH;
            end
         end
         FETCH: begin
            if (!iss_q) begin
               ds_en_d = 1'b1; ds_rd_d = 1'b1; ds_id_d = c; iss_d = 1'b1;
               ds_addr_d = {ptag, pidx, 4'b0};
            end else if (resp) begin
               iss_d  = 1'b0;
               fill_d = cacheline_DtoS;
               fsm_d  = FILL;
            end
         end
         FILL: begin
            if (pw) merged[{pws, 5'd0} +: 32] = pdat_q[c];
            else begin
               dout_d[c] = fill_q[{pws, 5'd0} +: 32];
               vld_d[c]  = 1'b1;
            end
            dat_d[c][pidx] = merged;
            tag_d[c][pidx] = ptag;
            st_d[c][pidx]  = pw ? ST_M : ST_S;
            pend_d[c] = 1'b0; ready_d[c] = 1'b1; fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q <= '0; tag_q <= '0; dat_q <= '0;
         ready_q <= 2'b11; pend_q <= '0; pwr_q <= '0; vld_q <= '0;
         paddr_q <= '0; pdat_q <= '0; dout_q <= '0;
         fsm_q <= IDLE; cur_q <= 1'b0; iss_q <= 1'b0; rr_q <= 1'b0; fill_q <= '0;
         ds_en_q <= 1'b0; ds_wr_q <= 1'b0; ds_rd_q <= 1'b0; ds_id_q <= 1'b0;
         ds_addr_q <= '0; ds_line_q <= '0;
      end else begin
         st_q <= st_d; tag_q <= tag_d; dat_q <= dat_d;
         ready_q <= ready_d; pend_q <= pend_d; pwr_q <= pwr_d; vld_q <= vld_d;
         paddr_q <= paddr_d; pdat_q <= pdat_d; dout_q <= dout_d;
         fsm_q <= fsm_d; cur_q <= cur_d; iss_q <= iss_d; rr_q <= rr_d; fill_q <= fill_d;
         ds_en_q <= ds_en_d; ds_wr_q <= ds_wr_d; ds_rd_q <= ds_rd_d; ds_id_q <= ds_id_d;
         ds_addr_q <= ds_addr_d; ds_line_q <= ds_line_d;
      end
   end

   assign interface_ready_a = ready_q[0];
   assign interface_ready_b = ready_q[1];
   assign data_out_a        = dout_q[0];
   assign data_out_b        = dout_q[1];
   assign data_out_valid_a  = vld_q[0];
   assign data_out_valid_b  = vld_q[1];
   assign mem_addr_StoD     = ds_addr_q;
   assign cacheline_StoD    = ds_line_q;
   assign wren_StoD         = ds_wr_q;
   assign rden_StoD         = ds_rd_q;
   assign downstream_enable = ds_en_q;
   assign client_id_StoD    = ds_id_q;
   assign pause_processors  = (fsm_q != IDLE);
endmodule

// File: tb/tb_l1_cache_pair_complex.sv
// Bench for l1_cache_pair_complex: directed vector table of CPU operations
// with hand-computed data and downstream traffic, against a small L2 model,
// plus sequences for collisions and reset during a fetch.
module tb_l1_cache_pair_complex;
   logic clk = 1'b0, reset = 1'b0;
   logic [31:0] addr_a = '0, data_a = '0, addr_b = '0, data_b = '0;
   logic rden_a = 1'b0, wren_a = 1'b0, rden_b = 1'b0, wren_b = 1'b0;
   logic rdy_a, rdy_b, vld_a, vld_b;
   logic [31:0] dout_a, dout_b, ds_addr;
   logic [127:0] ds_line, dtos_line;
   logic ds_wr, ds_rd, ds_en, ds_id, dtos_valid, dtos_id, pause;
   // L2 model response and manual response from the main sequence
   logic rsp_v = 1'b0, rsp_id = 1'b0, man_v = 1'b0, man_id = 1'b0;
   logic [127:0] rsp_line = '0;
   bit auto_resp = 1'b1;

   assign dtos_valid = rsp_v | man_v;
   assign dtos_id    = man_v ? man_id : rsp_id;
   assign dtos_line  = rsp_line;

   always #5 clk = ~clk;

   l1_cache_pair_complex dut (
      .clk(clk), .reset(reset),
      .addr_in_a(addr_a), .data_in_a(data_a), .rden_a(rden_a), .wren_a(wren_a),
      .interface_ready_a(rdy_a), .data_out_a(dout_a), .data_out_valid_a(vld_a),
      .addr_in_b(addr_b), .data_in_b(data_b), .rden_b(rden_b), .wren_b(wren_b),
      .interface_ready_b(rdy_b), .data_out_b(dout_b), .data_out_valid_b(vld_b),
      .mem_addr_StoD(ds_addr), .cacheline_StoD(ds_line), .wren_StoD(ds_wr),
      .rden_StoD(ds_rd), .downstream_enable(ds_en), .client_id_StoD(ds_id),
      .cacheline_DtoS(dtos_line), .valid_DtoS(dtos_valid), .client_id_DtoS(dtos_id),
      .pause_processors(pause));

   typedef struct { bit wr; logic [31:0] addr; bit id; } cmd_t;
   cmd_t cmd_log[$];
   logic [127:0] mem [logic [31:0]];

   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'h5A5A0000;
   endfunction
   function automatic logic [127:0] dline(input logic [31:0] l);
      return {f(l + 12), f(l + 8), f(l + 4), f(l)};
   endfunction

   // L2 model: logs every command, stores writes, answers after a short delay
   initial begin
      forever begin
         @(posedge clk); #1;
         if (ds_en) begin
            cmd_log.push_back('{ds_wr, ds_addr, ds_id});
            if (ds_wr) mem[ds_addr] = ds_line;
            if (auto_resp) begin
               rsp_line = ds_wr ? '0 : (mem.exists(ds_addr) ? mem[ds_addr] : dline(ds_addr));
               rsp_id = ds_id;
               @(posedge clk); #1; rsp_v = 1'b1;
               @(posedge clk); #1; rsp_v = 1'b0;
            end
         end
      end
   end

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request and wait (bounded) for it to complete
   task automatic do_req(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output bit gv, output logic [31:0] gd, output bit to);
      int n;
      gv = 0; gd = '0; to = 0; n = 0;
      while (!(p ? rdy_b : rdy_a) && n < 500) begin @(posedge clk); #1; n++; end
      if (p) begin addr_b = a; data_b = d; wren_b = w; rden_b = !w; end
      else   begin addr_a = a; data_a = d; wren_a = w; rden_a = !w; end
      @(posedge clk); #1;
      rden_a = 0; wren_a = 0; rden_b = 0; wren_b = 0;
      n = 0;
      forever begin
         if (p ? vld_b : vld_a) begin gv = 1; gd = p ? dout_b : dout_a; end
         if ((p ? rdy_b : rdy_a) && (w || gv)) break;
         if (n >= 500) begin to = 1; break; end
         @(posedge clk); #1; n++;
      end
   endtask

   typedef struct {
      bit p; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp;
      int n_ds; bit ds0_wr; logic [31:0] ds0_addr; bit ds0_id;
   } vec_t;
   vec_t vecs[16];

   initial begin
      bit gv, to, seen, rb, fid, gva, gvb;
      logic [31:0] gd, faddr, da, db;
      int base, n;
      mem[32'h2b0] = {32'h3, 32'h2, 32'h1, 32'hDEADBEEF};
      //          port wr  addr        wdata  expect rd    #ds wr0 addr0     id0
      vecs[0]  = '{0, 0, 32'h2b0,  0,     32'hDEADBEEF, 1, 0, 32'h2b0,  0};
      vecs[1]  = '{0, 0, 32'h2b0,  0,     32'hDEADBEEF, 0, 0, 0,        0};
      vecs[2]  = '{0, 0, 32'h2b8,  0,     32'h2,        0, 0, 0,        0};
      vecs[3]  = '{0, 1, 32'h2b4,  32'h11, 0,           0, 0, 0,        0};
      vecs[4]  = '{1, 0, 32'h2b4,  0,     32'h11,       2, 1, 32'h2b0,  1};
      vecs[5]  = '{0, 0, 32'h2b4,  0,     32'h11,       0, 0, 0,        0};
      vecs[6]  = '{1, 1, 32'h2b0,  32'h77, 0,           0, 0, 0,        0};
      vecs[7]  = '{0, 0, 32'h2b0,  0,     32'h77,       2, 1, 32'h2b0,  0};
      vecs[8]  = '{1, 0, 32'h2b0,  0,     32'h77,       0, 0, 0,        0};
      vecs[9]  = '{0, 1, 32'h100,  32'h5, 0,            1, 0, 32'h100,  0};
      vecs[10] = '{0, 1, 32'h104,  32'h9, 0,            0, 0, 0,        0};
      vecs[11] = '{0, 0, 32'h1100, 0,     32'h5A5A1100, 2, 1, 32'h100,  0};
      vecs[12] = '{0, 0, 32'h104,  0,     32'h9,        1, 0, 32'h100,  0};
      vecs[13] = '{0, 0, 32'h100,  0,     32'h5,        0, 0, 0,        0};
      vecs[14] = '{1, 0, 32'h3c0,  0,     32'h5A5A03C0, 1, 0, 32'h3c0,  1};
      vecs[15] = '{1, 0, 32'h3cc,  0,     32'h5A5A03CC, 0, 0, 0,        0};

      // Reset values
      repeat (3) @(posedge clk); #1;
      chk("rst_rdy_a", rdy_a, 1); chk("rst_rdy_b", rdy_b, 1);
      chk("rst_vld_a", vld_a, 0); chk("rst_vld_b", vld_b, 0);
      chk("rst_dout_a", dout_a, 0); chk("rst_dout_b", dout_b, 0);
      chk("rst_pause", pause, 0); chk("rst_ds_en", ds_en, 0);
      chk("rst_ds_cmd", {ds_wr, ds_rd}, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         base = cmd_log.size();
         do_req(vecs[i].p, vecs[i].wr, vecs[i].addr, vecs[i].wdata, gv, gd, to);
         chk($sformatf("v%0d_timeout", i), to, 0);
         if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), {gv, gd}, {1'b1, vecs[i].exp});
         chk($sformatf("v%0d_n_ds", i), cmd_log.size() - base, vecs[i].n_ds);
         if (vecs[i].n_ds > 0 && cmd_log.size() > base)
            chk($sformatf("v%0d_ds0", i), {cmd_log[base].wr, cmd_log[base].addr, cmd_log[base].id},
                {vecs[i].ds0_wr, vecs[i].ds0_addr, vecs[i].ds0_id});
         repeat (2) @(posedge clk); #1;
      end

      // Two collisions: a wins the first, b the second
      for (int k = 0; k < 2; k++) begin
         addr_a = k ? 32'h660 : 32'h440; addr_b = k ? 32'h770 : 32'h550;
         rden_a = 1; rden_b = 1;
         @(posedge clk); #1;
         rden_a = 0; rden_b = 0;
         seen = 0; rb = 1; fid = 0; faddr = '0; gva = 0; gvb = 0; da = '0; db = '0; n = 0;
         while (!(gva && gvb) && n < 1000) begin
            if (ds_en && !seen) begin
               seen = 1; fid = ds_id; faddr = ds_addr; rb = k ? rdy_a : rdy_b;
            end
            if (vld_a) begin gva = 1; da = dout_a; end
            if (vld_b) begin gvb = 1; db = dout_b; end
            @(posedge clk); #1; n++;
         end
         chk($sformatf("col%0d_done", k), {gva, gvb}, 2'b11);
         chk($sformatf("col%0d_first", k), {seen, fid, faddr},
             {1'b1, k[0], k ? 32'h770 : 32'h440});
         chk($sformatf("col%0d_loser_rdy", k), rb, 0);
         chk($sformatf("col%0d_data", k), {da, db},
             {f(k ? 32'h660 : 32'h440), f(k ? 32'h770 : 32'h550)});
         repeat (2) @(posedge clk); #1;
      end

      // Reset during FETCH; mismatched and late responses are ignored
      auto_resp = 0;
      addr_a = 32'h880; rden_a = 1;
      @(posedge clk); #1; rden_a = 0;
      n = 0;
      while (!ds_en && n < 50) begin @(posedge clk); #1; n++; end
      chk("r6_fetch", {ds_en, ds_rd, ds_addr, ds_id}, {1'b1, 1'b1, 32'h880, 1'b0});
      man_id = 1; man_v = 1;
      @(posedge clk); #1; man_v = 0;
      gv = 0;
      repeat (3) begin if (vld_a) gv = 1; @(posedge clk); #1; end
      chk("r6_mismatch_ignored", {pause, gv, rdy_a}, 3'b100);
      reset = 0;
      @(posedge clk); #1;
      reset = 1;
      man_id = 0; man_v = 1;
      @(posedge clk); #1; man_v = 0;
      gv = 0; seen = 0;
      repeat (5) begin if (vld_a) gv = 1; if (ds_en) seen = 1; @(posedge clk); #1; end
      chk("r6_late_rsp", {gv, seen, rdy_a, pause}, 4'b0010);
      auto_resp = 1;
      base = cmd_log.size();
      do_req(0, 0, 32'h880, 0, gv, gd, to);
      chk("r6_after_rst", {to, gv, gd}, {1'b0, 1'b1, f(32'h880)});
      chk("r6_after_rst_ds", cmd_log.size() - base, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
